// File: rtl/mem_stage_fwd_source.sv
// MEM stage of the pipelined LEGv8 core.
// Holds the EX/MEM and MEM/WB pipeline registers and runs the variable-latency
// data-memory handshake. Upstream stages are frozen while an access is outstanding.
// Also supplies the forwarding sources that EX reads back.
module mem_stage_fwd_source #(
  parameter int N        = 64,
  parameter int MAX_WAIT = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [4:0]   RegRd_E,
  input  logic         regWrite_E,
  input  logic         memRead_E,
  input  logic         memWrite_E,
  input  logic         memtoReg_E,
  output logic [N-1:0] EX_MEMResult,
  output logic [4:0]   EX_MEMRegRd,
  output logic         EX_MEMregWrite,
  output logic [N-1:0] memoryResult,
  output logic [4:0]   MEM_WBRegRd,
  output logic         MEM_WBregWrite,
  output logic         stall,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic [N-1:0] dm_rdata,
  input  logic         dm_ack,
  output logic         dm_err
);

  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // EX/MEM pipeline register
  logic [N-1:0] exm_result_r;
  logic [N-1:0] exm_wdata_r;
  logic [4:0]   exm_rd_r;
  logic         exm_regwrite_r;
  logic         exm_memread_r;
  logic         exm_memwrite_r;
  logic         exm_memtoreg_r;

  // MEM/WB pipeline register
  logic [N-1:0] mwb_result_r;
  logic [4:0]   mwb_rd_r;
  logic         mwb_regwrite_r;

  // Handshake FSM
  state_t       state_r;
  state_t       state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic         err_r;

  logic         memop_s;
  logic         req_s;
  logic         ack_s;
  logic         done_s;
  logic         stall_s;
  logic         timeout_s;
  logic [N-1:0] load_data_s;
  logic [N-1:0] wb_value_s;

  // Request, completion and stall decode; next state of the wait counter
  always_comb begin
    memop_s      = exm_memread_r | exm_memwrite_r;
    req_s        = 1'b0;
    state_next_s = ST_IDLE;
    cnt_next_s   = CNT_ZERO;
    case (state_r)
      ST_IDLE: req_s = memop_s;
      ST_BUSY: req_s = 1'b1;
      default: req_s = 1'b0;
    endcase
    if (reset) begin
      req_s = 1'b0;
    end else begin
      req_s = req_s;
    end
    // An acknowledge with no request outstanding is not ours; ignore it.
    ack_s     = dm_ack & req_s;
    done_s    = req_s & (dm_ack | (cnt_r == CNT_LAST));
    stall_s   = req_s & ~done_s;
    timeout_s = done_s & ~dm_ack;
    if (done_s) begin
      state_next_s = ST_IDLE;
      cnt_next_s   = CNT_ZERO;
    end else if (req_s) begin
      state_next_s = ST_BUSY;
      cnt_next_s   = cnt_r + CNT_ONE;
    end else begin
      state_next_s = ST_IDLE;
      cnt_next_s   = CNT_ZERO;
    end
    // A timed-out load returns zero rather than whatever is on the bus.
    if (ack_s) begin
      load_data_s = dm_rdata;
    end else begin
      load_data_s = {N{1'b0}};
    end
    if (exm_memtoreg_r) begin
      wb_value_s = load_data_s;
    end else begin
      wb_value_s = exm_result_r;
    end
  end

  // FSM state, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // EX/MEM register: capture when the pipe advances, hold while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      exm_result_r   <= {N{1'b0}};
      exm_wdata_r    <= {N{1'b0}};
      exm_rd_r       <= 5'd0;
      exm_regwrite_r <= 1'b0;
      exm_memread_r  <= 1'b0;
      exm_memwrite_r <= 1'b0;
      exm_memtoreg_r <= 1'b0;
    end else if (!stall_s) begin
      exm_result_r   <= aluResult_E;
      exm_wdata_r    <= writeData_E;
      exm_rd_r       <= RegRd_E;
      // XZR writes are dropped here so they can never be forwarded.
      exm_regwrite_r <= regWrite_E & (RegRd_E != 5'd31);
      exm_memread_r  <= memRead_E;
      exm_memwrite_r <= memWrite_E;
      exm_memtoreg_r <= memtoReg_E;
    end
  end

  // MEM/WB register: advance with the pipe, insert a bubble while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      mwb_result_r   <= {N{1'b0}};
      mwb_rd_r       <= 5'd0;
      mwb_regwrite_r <= 1'b0;
    end else if (!stall_s) begin
      mwb_result_r   <= wb_value_s;
      mwb_rd_r       <= exm_rd_r;
      mwb_regwrite_r <= exm_regwrite_r;
    end else begin
      mwb_regwrite_r <= 1'b0;
    end
  end

  assign EX_MEMResult   = exm_result_r;
  assign EX_MEMRegRd    = exm_rd_r;
  assign EX_MEMregWrite = exm_regwrite_r;
  assign memoryResult   = mwb_result_r;
  assign MEM_WBRegRd    = mwb_rd_r;
  assign MEM_WBregWrite = mwb_regwrite_r;
  assign stall          = stall_s;
  assign dm_req         = req_s;
  assign dm_we          = exm_memwrite_r;
  assign dm_addr        = exm_result_r;
  assign dm_wdata       = exm_wdata_r;
  assign dm_err         = err_r;

endmodule

// File: tb/tb_mem_stage_fwd_source.sv
// Bench for mem_stage_fwd_source: an instruction list (directed head plus random
// tail) flows through the stage while the bench plays a memory with a chosen
// acknowledge delay per access. Expectations come from instruction-level rules.
module tb_mem_stage_fwd_source;

  localparam int N    = 64;
  localparam int MAXW = 4;
  localparam int NI   = 48;
  localparam int MID  = 30;

  logic         clk;
  logic         reset;
  logic [N-1:0] aluResult_E, writeData_E, dm_rdata;
  logic [4:0]   RegRd_E;
  logic         regWrite_E, memRead_E, memWrite_E, memtoReg_E, dm_ack;
  logic [N-1:0] EX_MEMResult, memoryResult, dm_addr, dm_wdata;
  logic [4:0]   EX_MEMRegRd, MEM_WBRegRd;
  logic         EX_MEMregWrite, MEM_WBregWrite, stall, dm_req, dm_we, dm_err;

  mem_stage_fwd_source #(.N(N), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .RegRd_E(RegRd_E),
    .regWrite_E(regWrite_E), .memRead_E(memRead_E), .memWrite_E(memWrite_E),
    .memtoReg_E(memtoReg_E),
    .EX_MEMResult(EX_MEMResult), .EX_MEMRegRd(EX_MEMRegRd), .EX_MEMregWrite(EX_MEMregWrite),
    .memoryResult(memoryResult), .MEM_WBRegRd(MEM_WBRegRd), .MEM_WBregWrite(MEM_WBregWrite),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction list; a_k = dm_req cycle on which memory acks (0 = never)
  logic [N-1:0] a_res [NI];
  logic [N-1:0] a_wd  [NI];
  logic [N-1:0] a_rdat[NI];
  logic [4:0]   a_rd  [NI];
  logic         a_rw  [NI];
  logic         a_mr  [NI];
  logic         a_mw  [NI];
  logic         a_mt  [NI];
  int           a_k   [NI];

  int n_tests = 0;
  int n_fail  = 0;

  logic         exp_err;
  logic [N-1:0] prev_res;
  logic [4:0]   prev_rd;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input int idx);
    if (idx >= 0 && idx < NI) begin
      aluResult_E = a_res[idx]; writeData_E = a_wd[idx]; RegRd_E = a_rd[idx];
      regWrite_E  = a_rw[idx];  memRead_E   = a_mr[idx]; memWrite_E = a_mw[idx];
      memtoReg_E  = a_mt[idx];
    end else begin
      aluResult_E = '0; writeData_E = '0; RegRd_E = 5'd0;
      regWrite_E  = 1'b0; memRead_E = 1'b0; memWrite_E = 1'b0; memtoReg_E = 1'b0;
    end
  endtask

  task automatic run_seq(input int lo, input int hi);
    set_ex(lo);
    tick();
    for (int i = lo; i < hi; i++) begin
      logic         memop, acked, exp_stall, fwd_rw;
      logic [N-1:0] exp_res;
      memop  = a_mr[i] | a_mw[i];
      acked  = memop && (a_k[i] >= 1) && (a_k[i] <= MAXW);
      fwd_rw = a_rw[i] && (a_rd[i] != 5'd31);
      if (a_mt[i]) exp_res = acked ? a_rdat[i] : '0;
      else         exp_res = a_res[i];
      set_ex((i + 1 < hi) ? i + 1 : -1);
      for (int j = 0; j < MAXW + 2; j++) begin
        if (memop) begin
          dm_ack   = (a_k[i] == j + 1);
          dm_rdata = dm_ack ? a_rdat[i] : {$urandom, $urandom};
        end else begin
          dm_ack   = $urandom_range(0, 1) == 1;
          dm_rdata = {$urandom, $urandom};
        end
        #1;
        chk("exm_result", EX_MEMResult, a_res[i]);
        chk("exm_rd", EX_MEMRegRd, a_rd[i]);
        chk("exm_regwrite", EX_MEMregWrite, fwd_rw);
        chk("dm_req", dm_req, memop);
        if (memop) begin
          chk("dm_addr", dm_addr, a_res[i]);
          chk("dm_we", dm_we, a_mw[i]);
          chk("dm_wdata", dm_wdata, a_wd[i]);
        end
        exp_stall = memop && !((a_k[i] == j + 1) || (j == MAXW - 1));
        chk("stall", stall, exp_stall);
        if (j > 0) begin
          chk("mwb_bubble", MEM_WBregWrite, 1'b0);
          chk("mwb_hold_res", memoryResult, prev_res);
          chk("mwb_hold_rd", MEM_WBRegRd, prev_rd);
        end
        if (!exp_stall) break;
        tick();
      end
      tick();
      dm_ack = 1'b0;
      if (memop && !acked) exp_err = 1'b1;
      chk("mwb_result", memoryResult, exp_res);
      chk("mwb_rd", MEM_WBRegRd, a_rd[i]);
      chk("mwb_regwrite", MEM_WBregWrite, fwd_rw);
      chk("dm_err", dm_err, exp_err);
      prev_res = exp_res;
      prev_rd  = a_rd[i];
    end
  endtask

  initial begin
    // Random instruction list
    for (int i = 0; i < NI; i++) begin
      int t;
      t = $urandom_range(0, 3);
      a_res[i] = {$urandom, $urandom}; a_wd[i] = {$urandom, $urandom};
      a_rdat[i] = {$urandom, $urandom}; a_rd[i] = 5'($urandom_range(0, 31));
      a_k[i] = $urandom_range(0, 5);
      a_rw[i] = 1'b0; a_mr[i] = 1'b0; a_mw[i] = 1'b0; a_mt[i] = 1'b0;
      case (t)
        1: begin a_rw[i] = 1'b1; a_mr[i] = 1'b1; a_mt[i] = 1'b1; end
        2: a_mw[i] = 1'b1;
        default: a_rw[i] = ($urandom_range(0, 1) == 1);
      endcase
    end
    // Directed head: ALU op, same-cycle load, slow load, XZR write, timed-out store
    a_res[0] = 64'h10; a_rd[0] = 5'd3;  a_rw[0] = 1'b1; a_mr[0] = 1'b0; a_mw[0] = 1'b0; a_mt[0] = 1'b0;
    a_res[1] = 64'h8;  a_rd[1] = 5'd5;  a_rw[1] = 1'b1; a_mr[1] = 1'b1; a_mw[1] = 1'b0; a_mt[1] = 1'b1;
    a_k[1] = 1; a_rdat[1] = 64'hDEAD;
    a_res[2] = 64'h20; a_rd[2] = 5'd6;  a_rw[2] = 1'b1; a_mr[2] = 1'b1; a_mw[2] = 1'b0; a_mt[2] = 1'b1;
    a_k[2] = 4; a_rdat[2] = 64'hBEEF;
    a_res[3] = 64'h5;  a_rd[3] = 5'd31; a_rw[3] = 1'b1; a_mr[3] = 1'b0; a_mw[3] = 1'b0; a_mt[3] = 1'b0;
    a_res[4] = 64'h40; a_wd[4] = 64'h1234; a_rd[4] = 5'd0; a_rw[4] = 1'b0;
    a_mr[4] = 1'b0; a_mw[4] = 1'b1; a_mt[4] = 1'b0; a_k[4] = 0;
    // After the mid-run reset, a load that times out again
    a_mr[MID] = 1'b1; a_mw[MID] = 1'b0; a_mt[MID] = 1'b1; a_rw[MID] = 1'b1; a_k[MID] = 0;

    // Reset for two cycles
    reset = 1'b1; dm_ack = 1'b0; dm_rdata = '0; set_ex(-1);
    exp_err = 1'b0; prev_res = '0; prev_rd = 5'd0;
    tick(); tick();
    chk("rst_exm_result", EX_MEMResult, '0);
    chk("rst_exm_rd", EX_MEMRegRd, '0);
    chk("rst_exm_regwrite", EX_MEMregWrite, '0);
    chk("rst_mwb_result", memoryResult, '0);
    chk("rst_mwb_rd", MEM_WBRegRd, '0);
    chk("rst_mwb_regwrite", MEM_WBregWrite, '0);
    chk("rst_dm_req", dm_req, '0);
    chk("rst_stall", stall, '0);
    chk("rst_dm_err", dm_err, '0);
    chk("rst_dm_we", dm_we, '0);
    reset = 1'b0;

    run_seq(0, MID);

    // Abandon an outstanding load with reset
    aluResult_E = 64'h99; RegRd_E = 5'd7; regWrite_E = 1'b1;
    memRead_E = 1'b1; memWrite_E = 1'b0; memtoReg_E = 1'b1;
    tick();
    set_ex(-1); dm_ack = 1'b0;
    #1;
    chk("busy_req", dm_req, 1'b1);
    chk("busy_stall", stall, 1'b1);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_req", dm_req, 1'b0);
    tick();
    chk("rst_mid_exm_result", EX_MEMResult, '0);
    chk("rst_mid_mwb_result", memoryResult, '0);
    chk("rst_mid_err", dm_err, 1'b0);
    chk("rst_mid_stall", stall, 1'b0);
    chk("rst_mid_req2", dm_req, 1'b0);
    reset = 1'b0;
    exp_err = 1'b0; prev_res = '0; prev_rd = 5'd0;

    run_seq(MID, NI);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
